// File: rtl/vga_sprite_engine.sv
// 640x480 VGA timing generator that composites NUM_SPR solid-colour sprites over a
// background pixel stream; keyboard commands move/select sprites during vertical blank.
module vga_sprite_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int NUM_SPR   = 4,
   parameter int SPR_W     = 64,
   parameter int SPR_H     = 48,
   parameter int MOVE_STEP = 10
) (
   input  logic                  iVGA_CLK,
   input  logic                  iRST,
   input  logic [7:0]            key_in,
   input  logic                  key_en,
   input  logic [24*NUM_SPR-1:0] spr_color,
   input  logic [23:0]           bg_bgr,
   output logic [18:0]           oADDR,
   output logic [2:0]            sel_idx,
   output logic                  oHS,
   output logic                  oVS,
   output logic                  oBLANK_n,
   output logic [7:0]            b_data,
   output logic [7:0]            g_data,
   output logic [7:0]            r_data
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  X_MAX    = 10'(H_ACTIVE - SPR_W);
   localparam logic [9:0]  Y_MAX    = 10'(V_ACTIVE - SPR_H);
   localparam logic [9:0]  STEP     = 10'(MOVE_STEP);
   localparam logic [10:0] SPR_W11  = 11'(SPR_W);
   localparam logic [10:0] SPR_H11  = 11'(SPR_H);
   localparam logic [18:0] ADDR_MUL = 19'(H_ACTIVE);
   localparam logic [2:0]  SEL_LAST = 3'(NUM_SPR - 1);

   typedef enum logic [2:0] {
      CMD_UP,
      CMD_DOWN,
      CMD_LEFT,
      CMD_RIGHT,
      CMD_SEL
   } cmd_t;

   function automatic logic [9:0] step_down(input logic [9:0] p);
      return (p < STEP) ? 10'd0 : p - STEP;
   endfunction

   function automatic logic [9:0] step_up(input logic [9:0] p, input logic [9:0] lim);
      logic [10:0] s;
      s = {1'b0, p} + {1'b0, STEP};
      return (s > {1'b0, lim}) ? lim : s[9:0];
   endfunction

   logic [9:0]         h_reg;
   logic [9:0]         v_reg;
   logic               apply;
   logic               dec_valid;
   cmd_t               dec_cmd;
   logic               pend_valid_reg;
   cmd_t               pend_cmd_reg;
   logic [2:0]         sel_reg;
   logic               exec;
   logic [NUM_SPR-1:0] hit;
   logic [NUM_SPR-1:0] hit_reg;
   logic               act_reg;
   logic               hs_reg;
   logic               vs_reg;
   logic               active;
   logic [18:0]        addr_next;
   logic [23:0]        pixel_next;

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         h_reg <= '0;
         v_reg <= '0;
      end else if (h_reg == H_LAST) begin
         h_reg <= '0;
         v_reg <= (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
      end else begin
         h_reg <= h_reg + 10'd1;
      end
   end

   // First clock of the first blank line: the only moment sprite state may change.
   assign apply = (h_reg == 10'd0) && (v_reg == V_ACT);
   assign exec  = apply && pend_valid_reg;

   always_comb begin
      dec_valid = 1'b1;
      dec_cmd   = CMD_UP;
      case (key_in)
         8'h75:   dec_cmd = CMD_UP;
         8'h72:   dec_cmd = CMD_DOWN;
         8'h6b:   dec_cmd = CMD_LEFT;
         8'h74:   dec_cmd = CMD_RIGHT;
         8'h5a:   dec_cmd = CMD_SEL;
         default: dec_valid = 1'b0;
      endcase
   end

   // A key landing on the apply clock survives as the next frame's command.
   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         pend_valid_reg <= 1'b0;
         pend_cmd_reg   <= CMD_UP;
         sel_reg        <= '0;
      end else begin
         if (apply) begin
            pend_valid_reg <= 1'b0;
            if (pend_valid_reg && pend_cmd_reg == CMD_SEL)
               sel_reg <= (sel_reg == SEL_LAST) ? 3'd0 : sel_reg + 3'd1;
         end
         if (key_en && dec_valid) begin
            pend_valid_reg <= 1'b1;
            pend_cmd_reg   <= dec_cmd;
         end
      end
   end

   assign sel_idx = sel_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPR; gi++) begin : g_spr
         logic [9:0] x_reg;
         logic [9:0] y_reg;

         always_ff @(posedge iVGA_CLK) begin
            if (iRST) begin
               x_reg <= 10'(gi * SPR_W);
               y_reg <= '0;
            end else if (exec && sel_reg == 3'(gi)) begin
               case (pend_cmd_reg)
                  CMD_UP:    y_reg <= step_down(y_reg);
                  CMD_DOWN:  y_reg <= step_up(y_reg, Y_MAX);
                  CMD_LEFT:  x_reg <= step_down(x_reg);
                  CMD_RIGHT: x_reg <= step_up(x_reg, X_MAX);
                  default:   ;
               endcase
            end
         end

         assign hit[gi] = ({1'b0, h_reg} >= {1'b0, x_reg}) &&
                          ({1'b0, h_reg} <  {1'b0, x_reg} + SPR_W11) &&
                          ({1'b0, v_reg} >= {1'b0, y_reg}) &&
                          ({1'b0, v_reg} <  {1'b0, y_reg} + SPR_H11);
      end
   endgenerate

   assign active    = (h_reg < H_ACT) && (v_reg < V_ACT);
   assign addr_next = 19'(v_reg) * ADDR_MUL + 19'(h_reg);

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         act_reg <= 1'b0;
         hs_reg  <= 1'b1;
         vs_reg  <= 1'b1;
         hit_reg <= '0;
         oADDR   <= '0;
      end else begin
         act_reg <= active;
         hs_reg  <= !((h_reg >= HS_START) && (h_reg < HS_END));
         vs_reg  <= !((v_reg >= VS_START) && (v_reg < VS_END));
         hit_reg <= hit;
         oADDR   <= active ? addr_next : 19'd0;
      end
   end

   // Scanning from the top index down lets the lowest-index hit win.
   always_comb begin
      pixel_next = bg_bgr;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (hit_reg[i])
            pixel_next = spr_color[24*i +: 24];
      end
      if (!act_reg)
         pixel_next = 24'd0;
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         oHS      <= 1'b1;
         oVS      <= 1'b1;
         oBLANK_n <= 1'b0;
         b_data   <= '0;
         g_data   <= '0;
         r_data   <= '0;
      end else begin
         oHS      <= hs_reg;
         oVS      <= vs_reg;
         oBLANK_n <= act_reg;
         b_data   <= pixel_next[23:16];
         g_data   <= pixel_next[15:8];
         r_data   <= pixel_next[7:0];
      end
   end

endmodule
